// File: rtl/if_fetch.sv
// Instruction-fetch sequencer: one outstanding request on the SRAM-like bus,
// buffers the returned word for decode, and drops responses orphaned by a flush.
module if_fetch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    input  logic             id_stall,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             pc_en,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst,
    output logic             if_adel
);

    typedef enum logic [1:0] {REQ, WAIT, OUT, DISCARD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic [WIDTH-1:0] if_inst_q, if_inst_d;
    logic             if_adel_q, if_adel_d;
    logic             misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    // Request is suppressed under reset so the PC register never advances then.
    assign inst_req  = (state_q == REQ) && !flush && !misaligned && !rst;
    assign inst_addr = pc;
    assign pc_en     = inst_req & inst_addr_ok;

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_adel  = if_adel_q;

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_adel_d  = if_adel_q;
        unique case (state_q)
            REQ: begin
                if (flush) begin
                    if_valid_d = 1'b0;
                end else if (misaligned) begin
                    if_pc_d    = pc;
                    if_inst_d  = '0;
                    if_adel_d  = 1'b1;
                    if_valid_d = 1'b1;
                    state_d    = OUT;
                end else if (inst_addr_ok) begin
                    req_pc_d = pc;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    if_valid_d = 1'b0;
                    state_d    = inst_data_ok ? REQ : DISCARD;
                end else if (inst_data_ok) begin
                    if_inst_d  = inst_rdata;
                    if_pc_d    = req_pc_q;
                    if_adel_d  = 1'b0;
                    if_valid_d = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (flush || !id_stall) begin
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            DISCARD: begin
                // A second flush changes nothing here; the orphaned response still drains.
                if_valid_d = 1'b0;
                if (inst_data_ok) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REQ;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_adel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_adel_q  <= if_adel_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: each task drives one scenario and checks inline.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        id_stall;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        pc_en;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int checks = 0;
    int errors = 0;
    int pc_en_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (pc_en === 1'b1) pc_en_cnt <= pc_en_cnt + 1;

    if_fetch #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush), .id_stall(id_stall),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .pc_en(pc_en),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel)
    );

    // Advance one cycle; inputs change #1 after the edge, checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'h0; flush = 1'b0; id_stall = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        tick(); tick(); #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
        checks++; if (if_inst !== 32'h0 || if_adel !== 1'b0) begin errors++; $display("FAIL reset_inst_adel got %h/%b exp 0/0", if_inst, if_adel); end
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", inst_req); end
    endtask

    task automatic test_basic_fetch();
        int c0;
        rst = 1'b0; pc = 32'hBFC00000; inst_addr_ok = 1'b1; #1;
        c0 = pc_en_cnt;
        checks++; if (inst_req !== 1'b1 || pc_en !== 1'b1 || inst_addr !== 32'hBFC00000) begin errors++; $display("FAIL basic_req got req=%b en=%b addr=%h exp 1/1/bfc00000", inst_req, pc_en, inst_addr); end
        tick(); pc = 32'hBFC00004; inst_addr_ok = 1'b0; #1;
        checks++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL basic_wait got req=%b valid=%b exp 0/0", inst_req, if_valid); end
        tick(); inst_data_ok = 1'b1; inst_rdata = 32'h24080001; #1;
        tick(); inst_data_ok = 1'b0; inst_rdata = 32'h0; id_stall = 1'b0; #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC00000 || if_inst !== 32'h24080001 || if_adel !== 1'b0)
            begin errors++; $display("FAIL basic_out got v=%b pc=%h inst=%h adel=%b exp 1/bfc00000/24080001/0", if_valid, if_pc, if_inst, if_adel); end
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL basic_out_req got %b exp 0", inst_req); end
        tick(); #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %b exp 0", if_valid); end
        checks++; if (pc_en_cnt - c0 !== 1) begin errors++; $display("FAIL basic_pc_en_pulses got %0d exp 1", pc_en_cnt - c0); end
    endtask

    task automatic test_addr_backpressure();
        int c0;
        pc = 32'hBFC00000; inst_addr_ok = 1'b0; #1;
        c0 = pc_en_cnt;
        for (int i = 0; i < 3; i++) begin
            checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000 || pc_en !== 1'b0)
                begin errors++; $display("FAIL hold_req cyc%0d got req=%b addr=%h en=%b exp 1/bfc00000/0", i, inst_req, inst_addr, pc_en); end
            tick();
        end
        inst_addr_ok = 1'b1; #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000 || pc_en !== 1'b1)
            begin errors++; $display("FAIL hold_accept got req=%b addr=%h en=%b exp 1/bfc00000/1", inst_req, inst_addr, pc_en); end
        tick(); inst_addr_ok = 1'b0; pc = 32'hBFC00004; #1;
        checks++; if (pc_en_cnt - c0 !== 1) begin errors++; $display("FAIL hold_pc_en_pulses got %0d exp 1", pc_en_cnt - c0); end
    endtask

    task automatic test_stall();
        inst_data_ok = 1'b1; inst_rdata = 32'h8C020010; #1;
        tick(); inst_data_ok = 1'b0; inst_rdata = 32'h0; id_stall = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC00000 || if_inst !== 32'h8C020010 || inst_req !== 1'b0)
                begin errors++; $display("FAIL stall_hold cyc%0d got v=%b pc=%h inst=%h req=%b exp 1/bfc00000/8c020010/0", i, if_valid, if_pc, if_inst, inst_req); end
            if (i < 3) tick();
        end
        id_stall = 1'b0; #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL stall_release_req got %b exp 0", inst_req); end
        tick(); #1;
        checks++; if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00004)
            begin errors++; $display("FAIL stall_next got v=%b req=%b addr=%h exp 0/1/bfc00004", if_valid, inst_req, inst_addr); end
    endtask

    task automatic test_flush();
        bit seen_bad = 1'b0;
        flush = 1'b1; inst_addr_ok = 1'b1; #1;
        checks++; if (inst_req !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL flush_req_state got req=%b en=%b exp 0/0", inst_req, pc_en); end
        tick(); flush = 1'b0; pc = 32'hBFC00010; #1;
        tick(); inst_addr_ok = 1'b0; pc = 32'hBFC00014; flush = 1'b1; #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL flush_wait_req got %b exp 0", inst_req); end
        tick(); flush = 1'b0; pc = 32'hBFC00380; #1;
        if (if_inst === 32'hDEADBEEF && if_valid === 1'b1) seen_bad = 1'b1;
        checks++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got req=%b v=%b exp 0/0", inst_req, if_valid); end
        tick(); inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF; #1;
        if (if_inst === 32'hDEADBEEF && if_valid === 1'b1) seen_bad = 1'b1;
        tick(); inst_data_ok = 1'b0; inst_rdata = 32'h0; #1;
        if (if_inst === 32'hDEADBEEF || if_valid === 1'b1) seen_bad = 1'b1;
        checks++; if (seen_bad !== 1'b0) begin errors++; $display("FAIL flush_dropped got presented=%b exp 0", seen_bad); end
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00380) begin errors++; $display("FAIL flush_redirect got req=%b addr=%h exp 1/bfc00380", inst_req, inst_addr); end
    endtask

    task automatic test_misaligned();
        pc = 32'hBFC00002; inst_addr_ok = 1'b1; #1;
        checks++; if (inst_req !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL adel_req got req=%b en=%b exp 0/0", inst_req, pc_en); end
        tick(); inst_addr_ok = 1'b0; id_stall = 1'b0; #1;
        checks++; if (if_valid !== 1'b1 || if_adel !== 1'b1 || if_pc !== 32'hBFC00002 || if_inst !== 32'h0)
            begin errors++; $display("FAIL adel_out got v=%b adel=%b pc=%h inst=%h exp 1/1/bfc00002/0", if_valid, if_adel, if_pc, if_inst); end
        pc = 32'hBFC00100;
        tick(); #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL adel_consumed got %b exp 0", if_valid); end
    endtask

    task automatic test_reset_mid();
        inst_addr_ok = 1'b1; #1;
        tick(); inst_addr_ok = 1'b0; rst = 1'b1; #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b exp 0", inst_req); end
        tick(); #1;
        checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || if_adel !== 1'b0 || inst_req !== 1'b0)
            begin errors++; $display("FAIL rst_mid_regs got v=%b pc=%h inst=%h adel=%b req=%b exp all 0", if_valid, if_pc, if_inst, if_adel, inst_req); end
        rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h11111111; #1;
        tick(); inst_data_ok = 1'b0; inst_rdata = 32'h0; #1;
        checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00100)
            begin errors++; $display("FAIL rst_stray_data got v=%b inst=%h req=%b addr=%h exp 0/0/1/bfc00100", if_valid, if_inst, inst_req, inst_addr); end
        inst_addr_ok = 1'b1; #1;
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL rst_new_req got en=%b exp 1", pc_en); end
        tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h00000022; #1;
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC00100 || if_inst !== 32'h00000022)
            begin errors++; $display("FAIL rst_new_out got v=%b pc=%h inst=%h exp 1/bfc00100/00000022", if_valid, if_pc, if_inst); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_addr_backpressure();
        test_stall();
        test_flush();
        test_misaligned();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
